rom_dl_router: RTL and testbench
================================

# rom_dl_router

Upstream loader stage between `hps_io` and the `sky_skipper` core in the emu top level. It qualifies the raw ioctl download stream, forwards ROM bytes (index 0) as a registered write port toward the core's `dl_*` inputs, and captures the DIP bank (index 254). It also generates the core reset, which stays asserted through a download plus a fixed post-download hold, and reports whether the image size matched.

## Interface
Parameters:
- `ROM_SIZE`, default 86016 (0x15000): exact expected ROM image length in bytes; must be ≤ 131072.
- `HOLD_CYCLES`, default 4096: cycles `core_reset` stays high after a ROM download ends; must be ≥ 1.
- `DIP0_DEFAULT`, default 8'h00: reset value of `sw0`.
- `DIP1_DEFAULT`, default 8'hC2: reset value of `sw1`.
- `DIP2_DEFAULT`, default 8'h00: reset value of `sw2`.

Ports:
- `clk_sys`  in  1  system clock (40 MHz). This is the only clock.
- `reset_n`  in  1  synchronous active-low reset.
- `ioctl_download`  in  1  download active.
- `ioctl_index`  in  8  stream index: 0 = ROM, 254 = DIP.
- `ioctl_wr`  in  1  byte strobe, 1 cycle.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `dl_addr`  out  17  ROM write address.
- `dl_data`  out  8  ROM write data.
- `dl_wr`  out  1  ROM write strobe, 1 cycle.
- `sw0`, `sw1`, `sw2`  out  8 each  DIP bytes 0..2.
- `core_reset`  out  1  active-high reset to the core.
- `rom_ok`  out  1  last ROM download received exactly `ROM_SIZE` in-range bytes.
- `rom_err`  out  1  last ROM download had an out-of-range write or a size mismatch.

## Operation
The state machine has four states: IDLE, LOAD, HOLD, RUN.
- Reset: state IDLE, `core_reset`=1, `dl_wr`=0, `dl_addr`=0, `dl_data`=0, `rom_ok`=0, `rom_err`=0, `sw0..2`=DIP*_DEFAULT, byte counter 0, hold counter 0.
- IDLE: stays here, with `core_reset`=1, until the first ROM download. On `ioctl_download`=1 with index 0, go to LOAD.
- LOAD, entry: clear the byte counter, `rom_ok` and `rom_err`. `core_reset`=1 throughout.
- LOAD, on `ioctl_wr` with `ioctl_addr` < ROM_SIZE: next cycle `dl_wr`=1, `dl_addr`=ioctl_addr[16:0], `dl_data`=ioctl_dout. The byte counter increments, saturating at ROM_SIZE.
- LOAD, on `ioctl_wr` with `ioctl_addr` ≥ ROM_SIZE: no `dl_wr`, counter unchanged, and the sticky error flag is set.
- LOAD, on the `ioctl_download` falling edge (or index change away from 0): `rom_ok` = (counter==ROM_SIZE && no error), `rom_err` = !rom_ok. Load HOLD_CYCLES-1 into the hold counter and go to HOLD.
- HOLD: `core_reset`=1 and the hold counter decrements. At 0, go to RUN; the HOLD state therefore lasts exactly HOLD_CYCLES cycles.
- RUN: `core_reset`=0. A new index-0 download re-enters LOAD, and `core_reset` rises on the same cycle the state changes.
- `rom_ok`=0 in RUN still releases `core_reset`. The top level drives only the LED and OSD from `rom_ok`/`rom_err`.
- DIP capture, in any state: an `ioctl_wr` with index 254 and `ioctl_addr`[24:3]==0 writes ioctl_dout into an internal 8-byte bank at addr[2:0].
  - `sw0..2` mirror bank bytes 0..2, registered, valid one cycle after the write.
  - Bytes 3..7 are stored but not output.
  - DIP writes never touch `dl_*` and never change state.
- Writes with any index other than 0 or 254 are ignored.
- Counter width is 17 bits. The address compare uses the full 25-bit `ioctl_addr`, so an address ≥ 2^17 is out of range and is never aliased.

## Timing
- `dl_*` latency is 1 cycle from `ioctl_wr`. `dl_wr` is high for exactly 1 cycle per accepted byte, and `dl_addr`/`dl_data` hold their values until the next accepted byte.
- Back-to-back `ioctl_wr` (every cycle) must be accepted without loss.
- A write on the same cycle as the `ioctl_download` fall is still processed and counted before the size check.
- `rom_ok`/`rom_err` update on the cycle LOAD→HOLD is taken, 1 cycle after the download fall.
- `reset_n`=0 mid-LOAD aborts the download: return to IDLE, `dl_wr`=0 next cycle, DIP bank back to defaults.
- If `ioctl_download` is still high when `reset_n` is released, IDLE re-enters LOAD on the next cycle. The partial load is then reported as an error.

## Test plan
- Full load: stream 86016 bytes at addr 0..0x14FFF, data = addr[7:0], one write every 4 cycles. Expect 86016 `dl_wr` pulses, each 1 cycle after its strobe with matching addr/data. After the fall: `rom_ok`=1, `rom_err`=0, `core_reset` low exactly 4096 cycles after LOAD exit.
- Short load: 1000 bytes, then the fall. Expect `rom_ok`=0, `rom_err`=1, `core_reset` still released after 4096 cycles.
- Out of range: a full load plus one write at addr 0x15000 and one at 0x20000. Expect no `dl_wr` for either, `rom_err`=1.
- DIP: write index 254 addr 0..2 = 8'h05, 8'h3F, 8'h01, plus addr 8 = 8'hFF. Expect `sw0`=05, `sw1`=3F, `sw2`=01 one cycle after each write, the addr-8 write ignored, and no `dl_wr`.
- Back-to-back: 16 consecutive-cycle writes, then the fall on the same cycle as the 16th write, with ROM_SIZE=16 in a second instance. Expect 16 pulses and `rom_ok`=1.
- Reset mid-load: `reset_n`=0 after 500 bytes. Expect `dl_wr`=0, `core_reset`=1, `sw1`=C2. On reload, the counter restarts from 0.

Source files
------------

// File: rtl/rom_dl_router.sv
// Qualifies the ioctl download stream into a ROM write port and a DIP bank, and holds core reset across loads.
// Latency: dl_*, sw* and status register one cycle after the strobe. No backpressure; one byte per cycle is accepted.
module rom_dl_router #(
    parameter int         ROM_SIZE     = 86016,
    parameter int         HOLD_CYCLES  = 4096,
    parameter logic [7:0] DIP0_DEFAULT = 8'h00,
    parameter logic [7:0] DIP1_DEFAULT = 8'hC2,
    parameter logic [7:0] DIP2_DEFAULT = 8'h00
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [16:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        dl_wr,
    output logic [7:0]  sw0,
    output logic [7:0]  sw1,
    output logic [7:0]  sw2,
    output logic        core_reset,
    output logic        rom_ok,
    output logic        rom_err
);

    localparam int CW = $clog2(ROM_SIZE + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] ROM_CNT   = CW'(ROM_SIZE);
    localparam logic [24:0]   ROM_END   = 25'(ROM_SIZE);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            err, err_nxt;
    logic [HW-1:0]   hold_cnt;
    logic            accept, oor, load_ok;
    logic [7:0]      dip_bank [8];
    logic            unused_dip_hi;

    logic rom_sel, rom_wr, in_range, dip_wr;
    assign rom_sel  = ioctl_download && (ioctl_index == 8'd0);
    assign rom_wr   = ioctl_wr && (ioctl_index == 8'd0);
    assign in_range = ioctl_addr < ROM_END;
    assign dip_wr   = ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == '0);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        oor       = 1'b0;
        case (state)
            IDLE: if (rom_sel) state_nxt = LOAD;
            LOAD: begin
                // The write on the cycle the download drops still counts.
                accept = rom_wr && in_range;
                oor    = rom_wr && !in_range;
                if (!rom_sel) state_nxt = HOLD;
            end
            HOLD: if (hold_cnt == '0) state_nxt = RUN;
            RUN:  if (rom_sel) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
        cnt_nxt = (accept && (cnt != ROM_CNT)) ? cnt + CW'(1) : cnt;
        err_nxt = err | oor;
        load_ok = (cnt_nxt == ROM_CNT) && !err_nxt;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dl_wr      <= 1'b0;
            dl_addr    <= '0;
            dl_data    <= '0;
            core_reset <= 1'b1;
            rom_ok     <= 1'b0;
            rom_err    <= 1'b0;
            cnt        <= '0;
            err        <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            dl_wr      <= accept;
            core_reset <= (state_nxt != RUN);
            if (accept) begin
                dl_addr <= ioctl_addr[16:0];
                dl_data <= ioctl_dout;
            end
            if ((state != LOAD) && (state_nxt == LOAD)) begin
                cnt     <= '0;
                err     <= 1'b0;
                rom_ok  <= 1'b0;
                rom_err <= 1'b0;
            end else if (state == LOAD) begin
                cnt <= cnt_nxt;
                err <= err_nxt;
                if (state_nxt == HOLD) begin
                    rom_ok   <= load_ok;
                    rom_err  <= !load_ok;
                    hold_cnt <= HOLD_LOAD;
                end
            end else if ((state == HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end

    // DIP bank is written in any state and is restored to defaults by reset.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dip_bank[0] <= DIP0_DEFAULT;
            dip_bank[1] <= DIP1_DEFAULT;
            dip_bank[2] <= DIP2_DEFAULT;
            for (int i = 3; i < 8; i++) dip_bank[i] <= '0;
        end else if (dip_wr) begin
            dip_bank[ioctl_addr[2:0]] <= ioctl_dout;
        end
    end

    assign sw0 = dip_bank[0];
    assign sw1 = dip_bank[1];
    assign sw2 = dip_bank[2];
    assign unused_dip_hi = ^{dip_bank[3], dip_bank[4], dip_bank[5], dip_bank[6], dip_bank[7]};

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed bench: default-size router plus a ROM_SIZE=16 / HOLD_CYCLES=4 router on shared ioctl inputs.
module tb_rom_dl_router;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [16:0] d_dl_addr, s_dl_addr;
    logic [7:0]  d_dl_data, s_dl_data;
    logic        d_dl_wr, s_dl_wr;
    logic [7:0]  d_sw0, d_sw1, d_sw2, s_sw0, s_sw1, s_sw2;
    logic        d_core_reset, s_core_reset;
    logic        d_rom_ok, s_rom_ok, d_rom_err, s_rom_err;

    int n_chk = 0;
    int n_err = 0;
    int d_pulses = 0;
    int s_pulses = 0;
    int cycles;

    always #5 clk_sys = ~clk_sys;

    rom_dl_router u_dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .dl_addr(d_dl_addr), .dl_data(d_dl_data), .dl_wr(d_dl_wr),
        .sw0(d_sw0), .sw1(d_sw1), .sw2(d_sw2), .core_reset(d_core_reset),
        .rom_ok(d_rom_ok), .rom_err(d_rom_err)
    );

    rom_dl_router #(.ROM_SIZE(16), .HOLD_CYCLES(4)) u_small (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .dl_addr(s_dl_addr), .dl_data(s_dl_data), .dl_wr(s_dl_wr),
        .sw0(s_sw0), .sw1(s_sw1), .sw2(s_sw2), .core_reset(s_core_reset),
        .rom_ok(s_rom_ok), .rom_err(s_rom_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk_sys);
        d_pulses += int'(d_dl_wr);
        s_pulses += int'(s_dl_wr);
    endtask

    task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_wr    = 1'b1;
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        step();
        ioctl_wr    = 1'b0;
    endtask

    task automatic wait_run_small(input int expect_cycles);
        cycles = 0;
        while (s_core_reset && cycles < 100) begin
            step();
            cycles++;
        end
        chk("s_hold_len", 32'(cycles), 32'(expect_cycles));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
        ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
        repeat (3) step();

        chk("rst_core_reset", 32'(d_core_reset), 32'd1);
        chk("rst_dl_wr",      32'(d_dl_wr),      32'd0);
        chk("rst_dl_addr",    32'(d_dl_addr),    32'd0);
        chk("rst_dl_data",    32'(d_dl_data),    32'd0);
        chk("rst_rom_ok",     32'(d_rom_ok),     32'd0);
        chk("rst_rom_err",    32'(d_rom_err),    32'd0);
        chk("rst_sw0",        32'(d_sw0),        32'h00);
        chk("rst_sw1",        32'(d_sw1),        32'hC2);
        chk("rst_sw2",        32'(d_sw2),        32'h00);
        reset_n = 1'b1;
        step();

        // DIP bank, with the download flag up for index 254 only.
        ioctl_download = 1'b1;
        wr_byte(8'd254, 25'd0, 8'h05);
        chk("dip_sw0", 32'(d_sw0), 32'h05);
        chk("dip_no_dlwr0", 32'(d_dl_wr), 32'd0);
        wr_byte(8'd254, 25'd1, 8'h3F);
        chk("dip_sw1", 32'(d_sw1), 32'h3F);
        wr_byte(8'd254, 25'd2, 8'h01);
        chk("dip_sw2", 32'(d_sw2), 32'h01);
        wr_byte(8'd254, 25'd8, 8'hFF);
        chk("dip_addr8_sw0", 32'(d_sw0), 32'h05);
        chk("dip_no_dlwr", 32'(d_dl_wr), 32'd0);
        ioctl_download = 1'b0;
        wr_byte(8'd1, 25'd0, 8'hAA);
        chk("other_idx_no_dlwr", 32'(d_dl_wr), 32'd0);
        chk("dip_still_idle", 32'(d_core_reset), 32'd1);

        // Short load of 1000 back-to-back bytes into the default-size router.
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        step();
        d_pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            wr_byte(8'd0, 25'(i), 8'(i));
            chk("short_dl_wr",   32'(d_dl_wr),   32'd1);
            chk("short_dl_addr", 32'(d_dl_addr), 32'(i));
            chk("short_dl_data", 32'(d_dl_data), 32'(i & 255));
        end
        chk("short_pulses", 32'(d_pulses), 32'd1000);
        chk("short_err_before_fall", 32'(d_rom_err), 32'd0);
        ioctl_download = 1'b0;
        step();
        chk("short_rom_ok",  32'(d_rom_ok),  32'd0);
        chk("short_rom_err", 32'(d_rom_err), 32'd1);
        cycles = 0;
        while (d_core_reset && cycles < 5000) begin
            step();
            cycles++;
        end
        chk("short_hold_len", 32'(cycles), 32'd4096);

        // Re-entry from RUN, then high-address writes.
        ioctl_download = 1'b1;
        step();
        chk("reload_core_reset", 32'(d_core_reset), 32'd1);
        chk("reload_err_clear",  32'(d_rom_err),    32'd0);
        wr_byte(8'd0, 25'h14FFF, 8'h5A);
        chk("top_dl_wr",   32'(d_dl_wr),   32'd1);
        chk("top_dl_addr", 32'(d_dl_addr), 32'h14FFF);
        chk("top_dl_data", 32'(d_dl_data), 32'h5A);
        wr_byte(8'd0, 25'h15000, 8'h11);
        chk("oor15000_dl_wr", 32'(d_dl_wr),   32'd0);
        wr_byte(8'd0, 25'h20000, 8'h22);
        chk("oor20000_dl_wr", 32'(d_dl_wr),   32'd0);
        chk("oor_addr_held",  32'(d_dl_addr), 32'h14FFF);

        // Reset in the middle of a 500-byte load, download left high.
        for (int i = 0; i < 500; i++) wr_byte(8'd0, 25'(i), 8'(i));
        reset_n = 1'b0;
        wr_byte(8'd0, 25'd500, 8'hEE);
        chk("midrst_dl_wr",      32'(d_dl_wr),      32'd0);
        chk("midrst_core_reset", 32'(d_core_reset), 32'd1);
        chk("midrst_sw1",        32'(d_sw1),        32'hC2);
        chk("midrst_sw0",        32'(d_sw0),        32'h00);
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 6; i++) wr_byte(8'd0, 25'(i), 8'(i));
        ioctl_download = 1'b0;
        step();
        chk("midrst_small_ok",  32'(s_rom_ok),  32'd0);
        chk("midrst_small_err", 32'(s_rom_err), 32'd1);
        chk("midrst_dut_err",   32'(d_rom_err), 32'd1);

        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();

        // Full load of the 16-byte router, one write every 4 cycles.
        ioctl_download = 1'b1;
        step();
        s_pulses = 0;
        for (int i = 0; i < 16; i++) begin
            wr_byte(8'd0, 25'(i), 8'(i) ^ 8'h5A);
            chk("full_dl_wr",   32'(s_dl_wr),   32'd1);
            chk("full_dl_addr", 32'(s_dl_addr), 32'(i));
            chk("full_dl_data", 32'(s_dl_data), 32'((i & 255) ^ 8'h5A));
            step();
            chk("full_dl_wr_low",  32'(s_dl_wr),   32'd0);
            chk("full_addr_held",  32'(s_dl_addr), 32'(i));
            step();
            step();
        end
        chk("full_pulses", 32'(s_pulses), 32'd16);
        ioctl_download = 1'b0;
        step();
        chk("full_rom_ok",     32'(s_rom_ok),     32'd1);
        chk("full_rom_err",    32'(s_rom_err),    32'd0);
        chk("full_core_reset", 32'(s_core_reset), 32'd1);
        wait_run_small(4);

        // Full load plus two out-of-range writes.
        ioctl_download = 1'b1;
        step();
        chk("oor_reentry_reset", 32'(s_core_reset), 32'd1);
        for (int i = 0; i < 16; i++) wr_byte(8'd0, 25'(i), 8'(i));
        wr_byte(8'd0, 25'd16, 8'h77);
        chk("oor16_dl_wr", 32'(s_dl_wr), 32'd0);
        wr_byte(8'd0, 25'h20000, 8'h88);
        chk("oor_alias_dl_wr", 32'(s_dl_wr),   32'd0);
        chk("oor_alias_addr",  32'(s_dl_addr), 32'd15);
        ioctl_download = 1'b0;
        step();
        chk("oor_rom_ok",  32'(s_rom_ok),  32'd0);
        chk("oor_rom_err", 32'(s_rom_err), 32'd1);
        wait_run_small(4);

        // Back-to-back, with the fall on the same cycle as the 16th write.
        ioctl_download = 1'b1;
        step();
        s_pulses = 0;
        for (int i = 0; i < 15; i++) wr_byte(8'd0, 25'(i), 8'(i));
        ioctl_download = 1'b0;
        wr_byte(8'd0, 25'd15, 8'hC3);
        chk("b2b_last_dl_wr",   32'(s_dl_wr),   32'd1);
        chk("b2b_last_dl_addr", 32'(s_dl_addr), 32'd15);
        chk("b2b_last_dl_data", 32'(s_dl_data), 32'hC3);
        chk("b2b_rom_ok",       32'(s_rom_ok),  32'd1);
        chk("b2b_rom_err",      32'(s_rom_err), 32'd0);
        step();
        chk("b2b_pulses", 32'(s_pulses), 32'd16);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
